opb_register_bank_ppc2simulink: RTL and testbench
=================================================

Name: opb_register_bank_ppc2simulink

Overview:
- Parametrised successor to the single software-writable control register.
- OPB slave exposing C_NUM_REGS 32-bit PPC-writable, read-back-capable registers to Simulink user logic.
- Adds byte-enable writes, per-register write strobes and out-of-range handling.
- Runs entirely on OPB_Clk; user logic consuming the outputs is synchronous to OPB_Clk.

Parameters:
- C_BASEADDR, 32'h01004000, first byte address of the bank.
- C_HIGHADDR, 32'h010040FF, last byte address decoded by the bank.
- C_OPB_AWIDTH, 32, OPB address width.
- C_OPB_DWIDTH, 32, OPB data width (fixed 32).
- C_NUM_REGS, 4, number of user registers (1..32).
- C_RESET_VAL, 32'h00000000, reset value loaded into every register.

Ports:
- OPB_Clk  in  1  sole clock.
- OPB_Rst  in  1  synchronous active-high reset.
- OPB_ABus  in  [0:31]  OPB address.
- OPB_BE  in  [0:3]  byte enables; BE[0] selects DBus[0:7] = user bits 31:24.
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1 = read, 0 = write.
- OPB_select  in  1  transfer request.
- OPB_seqAddr  in  1  ignored.
- Sl_DBus  out  [0:31]  read data; zero when not acking.
- Sl_errAck  out  1  tied 0.
- Sl_retry  out  1  tied 0.
- Sl_toutSup  out  1  tied 0.
- Sl_xferAck  out  1  transfer acknowledge.
- user_data_out  out  [C_NUM_REGS*32-1:0]  register i occupies bits [32i+31:32i].
- user_wr_strobe  out  [C_NUM_REGS-1:0]  1-cycle pulse when register i changes by write.

Behaviour:
- Clock and reset: single clock OPB_Clk; OPB_Rst is synchronous and active-high.
- Reset values:
  - All registers = C_RESET_VAL.
  - Sl_xferAck = 0, Sl_DBus = 0, user_wr_strobe = 0.
  - FSM = IDLE.
  - Reset mid-transfer aborts it with no ack.
- hit = OPB_select & (C_BASEADDR <= OPB_ABus <= C_HIGHADDR).
- idx = (OPB_ABus - C_BASEADDR) >> 2; low two address bits are ignored.
- FSM states:
  - IDLE: on hit, go to ACK; otherwise stay.
  - ACK: Sl_xferAck = 1 for exactly this cycle; go to HOLD.
  - HOLD: Sl_xferAck = 0; return to IDLE when OPB_select = 0, else stay. This prevents a double ack.
- Latency: hit at cycle N, ack at N+1, user_data_out and strobe updated at N+2.
- Write (RNW = 0), committed at the end of the ACK cycle when idx < C_NUM_REGS:
  - Each byte lane with BE = 1 is replaced; other lanes are kept.
  - user_wr_strobe[idx] = 1 for one cycle (N+2), even if the data is unchanged.
  - BE = 0000 writes nothing and raises no strobe.
- Read (RNW = 1):
  - During ACK, Sl_DBus = register[idx], bit-reversed so DBus[0] = bit 31.
  - In every other cycle Sl_DBus = 0 (OR-bus compliance).
- Out-of-range idx (idx >= C_NUM_REGS, still inside the address window): acked normally; reads return 0; writes are ignored with no strobe.
- Addresses outside the window: no response; Sl_DBus stays 0.

Optional Feature:
- Macro: OPB_REGBANK_SHADOW_EN.
- Defined:
  - Writes land in shadow registers with per-register dirty bits; reads return the shadow.
  - Commit word at idx = C_NUM_REGS:
    - A write with DBus[0] = 1 copies all shadows to user_data_out simultaneously at N+2.
    - The same commit pulses user_wr_strobe for every dirty register, then clears all dirty bits.
    - Reading the commit word returns the dirty vector in the low bits.
  - C_HIGHADDR must cover C_NUM_REGS+1 words.
  - Reset clears shadows to C_RESET_VAL and dirty bits to 0.
- Undefined: direct-write behaviour as above; the commit word is treated as out-of-range.

Test Plan:
- Reset, then read idx 0..3 -> Sl_DBus = 00000000 on each ack; exactly one Sl_xferAck per transfer; user_wr_strobe = 0.
- Write 0xDEADBEEF to idx 2 with BE = 1111:
  - Ack at N+1.
  - user_data_out[95:64] = DEADBEEF at N+2.
  - user_wr_strobe = 0100 for one cycle.
  - Readback returns DEADBEEF.
- Write 0x11223344 to idx 2 with BE = 0101 -> register = DE22BE44; strobe[2] pulses.
- Hold OPB_select high for 4 cycles after the ack -> no second ack; FSM stays in HOLD; the next transfer is acked normally after select drops.
- Write to idx 5 with C_NUM_REGS = 4 (inside the window) -> acked; no strobe; no register changes; read of idx 5 returns 0.
- Assert OPB_Rst in the ACK cycle of a write -> no register update; Sl_xferAck = 0 next cycle; all outputs at reset values.
- (SHADOW_EN) Write idx 0 = 0xA, then idx 3 = 0xB:
  - Outputs unchanged; commit read = 0x9.
  - Commit write 0x80000000 -> both outputs update at the same cycle; strobe = 1001; a subsequent commit read = 0.

Source files
------------

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing C_NUM_REGS byte-writable, read-back 32-bit registers to user logic.
// Define OPB_REGBANK_SHADOW_EN for shadowed writes with an atomic commit word at idx C_NUM_REGS.
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h01004000,
  parameter logic [31:0] C_HIGHADDR   = 32'h010040FF,
  parameter int unsigned C_OPB_AWIDTH = 32,
  parameter int unsigned C_OPB_DWIDTH = 32,
  parameter int unsigned C_NUM_REGS   = 4,
  parameter logic [31:0] C_RESET_VAL  = 32'h00000000
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:3]                OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic                      Sl_xferAck,
  output logic [C_NUM_REGS*32-1:0]  user_data_out,
  output logic [C_NUM_REGS-1:0]     user_wr_strobe
);

  typedef enum logic [1:0] {StIdle, StAck, StHold} state_e;
  typedef logic [C_NUM_REGS-1:0][31:0] bank_t;

  localparam bank_t ResetBank = {C_NUM_REGS{C_RESET_VAL}};

  state_e                state_q, state_d;
  logic                  rnw_q, rnw_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [29:0]           idx_q, idx_d;
  bank_t                 data_q, data_d;
  logic [C_NUM_REGS-1:0] strobe_q, strobe_d;

  logic [31:0]           abus, offset, rdata;
  logic                  hit, wr_cycle;
  logic [C_NUM_REGS-1:0] sel, wr;
  bank_t                 src, upd;
  logic [31:0]           rd_chain [C_NUM_REGS+1];

`ifdef OPB_REGBANK_SHADOW_EN
  bank_t                 shadow_q, shadow_d;
  logic [C_NUM_REGS-1:0] dirty_q, dirty_d;
  logic                  commit;
`endif

  // BE[3] here is OPB_BE[0], i.e. the lane holding user bits 31:24.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  assign abus   = OPB_ABus;
  assign hit    = OPB_select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
  assign offset = abus - C_BASEADDR;

  assign wr_cycle = (state_q == StAck) && !rnw_q && (be_q != 4'h0);

`ifdef OPB_REGBANK_SHADOW_EN
  assign src    = shadow_q;
  assign commit = (state_q == StAck) && !rnw_q && (idx_q == 30'(C_NUM_REGS)) && wdata_q[31];
`else
  assign src    = data_q;
`endif

  assign rd_chain[0] = 32'h0;
  for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_reg
    assign sel[i]        = (idx_q == 30'(i));
    assign wr[i]         = wr_cycle && sel[i];
    assign upd[i]        = wr[i] ? merge_bytes(src[i], wdata_q, be_q) : src[i];
    assign rd_chain[i+1] = rd_chain[i] | (sel[i] ? src[i] : 32'h0);
  end

  // Transfer FSM; the bus fields are captured on the hit so ACK works from stable copies.
  always_comb begin
    state_d = state_q;
    rnw_d   = rnw_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (hit) begin
          state_d = StAck;
          rnw_d   = OPB_RNW;
          be_d    = OPB_BE;
          wdata_d = OPB_DBus;
          idx_d   = offset[31:2];
        end
      end
      StAck:   state_d = StHold;
      StHold:  if (!OPB_select) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
`ifdef OPB_REGBANK_SHADOW_EN
    shadow_d = upd;
    dirty_d  = commit ? '0 : (dirty_q | wr);
    data_d   = commit ? shadow_q : data_q;
    strobe_d = commit ? dirty_q : '0;
    rdata    = (idx_q == 30'(C_NUM_REGS)) ? 32'(dirty_q) : rd_chain[C_NUM_REGS];
`else
    data_d   = upd;
    strobe_d = wr;
    rdata    = rd_chain[C_NUM_REGS];
`endif
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q  <= StIdle;
      rnw_q    <= 1'b0;
      be_q     <= 4'h0;
      wdata_q  <= 32'h0;
      idx_q    <= 30'h0;
      data_q   <= ResetBank;
      strobe_q <= '0;
`ifdef OPB_REGBANK_SHADOW_EN
      shadow_q <= ResetBank;
      dirty_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rnw_q    <= rnw_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
`ifdef OPB_REGBANK_SHADOW_EN
      shadow_q <= shadow_d;
      dirty_q  <= dirty_d;
`endif
    end
  end

  // Read data is gated to the ack cycle so the slave never pollutes the OR-ed bus.
  assign Sl_xferAck     = (state_q == StAck);
  assign Sl_DBus        = (Sl_xferAck && rnw_q) ? rdata : 32'h0;
  assign Sl_errAck      = 1'b0;
  assign Sl_retry       = 1'b0;
  assign Sl_toutSup     = 1'b0;
  assign user_data_out  = data_q;
  assign user_wr_strobe = strobe_q;

  logic unused_sig;
  assign unused_sig = ^{OPB_seqAddr, offset[1:0]};

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Bench for opb_register_bank_ppc2simulink: directed vector table, corner sequences and
// randomized transfers checked against a word/byte-lane model of the register bank.
module tb_opb_register_bank_ppc2simulink;

  localparam int          NR   = 4;
  localparam logic [31:0] BASE = 32'h01004000;
  localparam logic [31:0] HIGH = 32'h010040FF;

  logic              clk = 1'b0;
  logic              rst;
  logic [0:31]       abus, dbus, sl_dbus;
  logic [0:3]        be;
  logic              rnw, sel, seq;
  logic              errack, retry, tout, xack;
  logic [NR*32-1:0]  uout;
  logic [NR-1:0]     strobe;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0]   m_reg [NR];
  logic [31:0]   m_sh  [NR];
  logic [NR-1:0] m_dirty;

  typedef struct {
    logic [31:0]      addr;
    logic             rnw;
    logic [3:0]       be;
    logic [31:0]      wd;
    int               ack;
    logic [31:0]      rd;
    logic [NR-1:0]    strb;
    logic [NR*32-1:0] u;
  } vec_t;

  always #5 clk = ~clk;

  opb_register_bank_ppc2simulink dut (
    .OPB_Clk        (clk),
    .OPB_Rst        (rst),
    .OPB_ABus       (abus),
    .OPB_BE         (be),
    .OPB_DBus       (dbus),
    .OPB_RNW        (rnw),
    .OPB_select     (sel),
    .OPB_seqAddr    (seq),
    .Sl_DBus        (sl_dbus),
    .Sl_errAck      (errack),
    .Sl_retry       (retry),
    .Sl_toutSup     (tout),
    .Sl_xferAck     (xack),
    .user_data_out  (uout),
    .user_wr_strobe (strobe)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One complete transfer: request, ack cycle, strobe cycle, then back to idle.
  task automatic xfer(input logic [31:0] addr, input logic rd_nwr, input logic [3:0] ben,
                      input logic [31:0] wd, output int acks, output logic [31:0] rd,
                      output logic [NR-1:0] strb, output logic [NR-1:0] strb_late,
                      output logic [NR*32-1:0] u, output logic [31:0] idle_db);
    abus = addr;
    rnw  = rd_nwr;
    be   = ben;
    dbus = wd;
    sel  = 1'b1;
    acks = 0;
    rd   = 32'h0;
    step();
    if (xack) begin
      acks++;
      rd = sl_dbus;
    end
    sel = 1'b0;
    step();
    acks += int'(xack);
    strb    = strobe;
    u       = uout;
    idle_db = sl_dbus;
    step();
    acks += int'(xack);
    strb_late = strobe;
    idle_db   = idle_db | sl_dbus;
  endtask

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] ben);
    logic [31:0] mask;
    mask = 32'h0;
    for (int b = 0; b < 4; b++) begin
      if (((ben >> b) & 4'd1) != 4'd0) mask = mask | (32'hFF << (8 * b));
    end
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  function automatic logic [31:0] model_read(input int unsigned idx);
`ifdef OPB_REGBANK_SHADOW_EN
    if (idx < NR) return m_sh[idx];
    if (idx == NR) return 32'(m_dirty);
    return 32'h0;
`else
    if (idx < NR) return m_reg[idx];
    return 32'h0;
`endif
  endfunction

  task automatic model_write(input int unsigned idx, input logic [31:0] wd, input logic [3:0] ben,
                             output logic [NR-1:0] strb);
    strb = '0;
`ifdef OPB_REGBANK_SHADOW_EN
    if (idx < NR && ben != 4'h0) begin
      m_sh[idx]    = lane_merge(m_sh[idx], wd, ben);
      m_dirty[idx] = 1'b1;
    end else if (idx == NR && wd[31]) begin
      for (int i = 0; i < NR; i++) m_reg[i] = m_sh[i];
      strb    = m_dirty;
      m_dirty = '0;
    end
`else
    if (idx < NR && ben != 4'h0) begin
      m_reg[idx] = lane_merge(m_reg[idx], wd, ben);
      strb[idx]  = 1'b1;
    end
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int               acks;
    logic [31:0]      rd, idle_db;
    logic [NR-1:0]    strb, strb_late;
    logic [NR*32-1:0] u;
    vec_t             tbl [15];
    logic [127:0]     u_a, u_b, u_c;

    rst  = 1'b1;
    sel  = 1'b0;
    abus = 32'h0;
    dbus = 32'h0;
    be   = 4'h0;
    rnw  = 1'b0;
    seq  = 1'b0;
    step();
    step();
    chk("rst.ack", 128'(xack), 0);
    chk("rst.dbus", 128'(sl_dbus), 0);
    chk("rst.strobe", 128'(strobe), 0);
    chk("rst.uout", uout, 0);
    chk("rst.tied", 128'({errack, retry, tout}), 0);
    rst = 1'b0;
    step();

`ifndef OPB_REGBANK_SHADOW_EN
    u_a = {32'h0, 32'hDEADBEEF, 64'h0};
    u_b = {32'h0, 32'hDE22BE44, 64'h0};
    u_c = {32'h0, 32'hDE22BE44, 32'hAA000000, 32'h0};
    tbl[0]  = '{BASE,          1'b1, 4'hF, 32'h0,        1, 32'h0,        4'h0, 128'h0};
    tbl[1]  = '{BASE + 32'hC,  1'b1, 4'hF, 32'h0,        1, 32'h0,        4'h0, 128'h0};
    tbl[2]  = '{BASE + 32'h8,  1'b0, 4'hF, 32'hDEADBEEF, 1, 32'h0,        4'h4, u_a};
    tbl[3]  = '{BASE + 32'h8,  1'b1, 4'hF, 32'h0,        1, 32'hDEADBEEF, 4'h0, u_a};
    tbl[4]  = '{BASE + 32'h8,  1'b0, 4'h5, 32'h11223344, 1, 32'h0,        4'h4, u_b};
    tbl[5]  = '{BASE + 32'hB,  1'b1, 4'hF, 32'h0,        1, 32'hDE22BE44, 4'h0, u_b};
    tbl[6]  = '{BASE + 32'h14, 1'b0, 4'hF, 32'hCAFEF00D, 1, 32'h0,        4'h0, u_b};
    tbl[7]  = '{BASE + 32'h14, 1'b1, 4'hF, 32'h0,        1, 32'h0,        4'h0, u_b};
    tbl[8]  = '{BASE + 32'h4,  1'b0, 4'h0, 32'hFFFFFFFF, 1, 32'h0,        4'h0, u_b};
    tbl[9]  = '{BASE - 32'h4,  1'b1, 4'hF, 32'h0,        0, 32'h0,        4'h0, u_b};
    tbl[10] = '{HIGH + 32'h1,  1'b0, 4'hF, 32'h12345678, 0, 32'h0,        4'h0, u_b};
    tbl[11] = '{BASE,          1'b0, 4'hF, 32'h0,        1, 32'h0,        4'h1, u_b};
    tbl[12] = '{HIGH - 32'h3,  1'b1, 4'hF, 32'h0,        1, 32'h0,        4'h0, u_b};
    tbl[13] = '{BASE + 32'h4,  1'b0, 4'h8, 32'hAABBCCDD, 1, 32'h0,        4'h2, u_c};
    tbl[14] = '{BASE + 32'h4,  1'b1, 4'hF, 32'h0,        1, 32'hAA000000, 4'h0, u_c};
    for (int i = 0; i < 15; i++) begin
      xfer(tbl[i].addr, tbl[i].rnw, tbl[i].be, tbl[i].wd, acks, rd, strb, strb_late, u, idle_db);
      chk($sformatf("vec%0d.ack", i), 128'(acks), 128'(tbl[i].ack));
      chk($sformatf("vec%0d.rd", i), 128'(rd), 128'(tbl[i].rd));
      chk($sformatf("vec%0d.strb", i), 128'(strb), 128'(tbl[i].strb));
      chk($sformatf("vec%0d.strb_late", i), 128'(strb_late), 0);
      chk($sformatf("vec%0d.uout", i), u, tbl[i].u);
      chk($sformatf("vec%0d.idle_dbus", i), 128'(idle_db), 0);
    end
`else
    xfer(BASE, 1'b0, 4'hF, 32'hA, acks, rd, strb, strb_late, u, idle_db);
    chk("sh.w0.strb", 128'(strb), 0);
    chk("sh.w0.uout", u, 0);
    xfer(BASE + 32'hC, 1'b0, 4'hF, 32'hB, acks, rd, strb, strb_late, u, idle_db);
    chk("sh.w3.strb", 128'(strb), 0);
    chk("sh.w3.uout", u, 0);
    xfer(BASE + 32'hC, 1'b1, 4'hF, 32'h0, acks, rd, strb, strb_late, u, idle_db);
    chk("sh.r3.rd", 128'(rd), 128'h0000000B);
    xfer(BASE + 32'h10, 1'b1, 4'hF, 32'h0, acks, rd, strb, strb_late, u, idle_db);
    chk("sh.dirty.rd", 128'(rd), 128'h9);
    xfer(BASE + 32'h10, 1'b0, 4'hF, 32'h80000000, acks, rd, strb, strb_late, u, idle_db);
    chk("sh.commit.strb", 128'(strb), 128'h9);
    chk("sh.commit.uout", u, {32'hB, 64'h0, 32'hA});
    chk("sh.commit.strb_late", 128'(strb_late), 0);
    xfer(BASE + 32'h10, 1'b1, 4'hF, 32'h0, acks, rd, strb, strb_late, u, idle_db);
    chk("sh.dirty2.rd", 128'(rd), 0);
`endif

    // Select held high long after the ack must not produce a second ack.
    abus = BASE + 32'h8;
    rnw  = 1'b1;
    be   = 4'hF;
    sel  = 1'b1;
    acks = 0;
    step();
    acks += int'(xack);
    for (int i = 0; i < 4; i++) begin
      step();
      acks += int'(xack);
    end
    chk("hold.acks", 128'(acks), 1);
    sel = 1'b0;
    step();
    step();
    xfer(BASE, 1'b1, 4'hF, 32'h0, acks, rd, strb, strb_late, u, idle_db);
    chk("hold.next.ack", 128'(acks), 1);

    // Reset landing on the ack cycle of a write aborts it.
    abus = BASE + 32'h4;
    rnw  = 1'b0;
    be   = 4'hF;
    dbus = 32'h12345678;
    sel  = 1'b1;
    step();
    chk("rstack.ack", 128'(xack), 1);
    rst = 1'b1;
    step();
    chk("rstack.ack_after", 128'(xack), 0);
    chk("rstack.dbus", 128'(sl_dbus), 0);
    chk("rstack.strobe", 128'(strobe), 0);
    chk("rstack.uout", uout, 0);
    rst = 1'b0;
    sel = 1'b0;
    step();
    xfer(BASE + 32'h4, 1'b1, 4'hF, 32'h0, acks, rd, strb, strb_late, u, idle_db);
    chk("rstack.readback.ack", 128'(acks), 1);
    chk("rstack.readback.rd", 128'(rd), 0);

    for (int i = 0; i < NR; i++) begin
      m_reg[i] = 32'h0;
      m_sh[i]  = 32'h0;
    end
    m_dirty = '0;

    for (int t = 0; t < 300; t++) begin
      int               k;
      logic [31:0]      addr, wd, exp_rd;
      logic [3:0]       ben;
      logic             r, in_win;
      int unsigned      idx;
      logic [NR-1:0]    exp_strb;
      logic [NR*32-1:0] exp_u;
      k = int'($urandom_range(0, 11));
      if (k < 8) addr = BASE + 32'(k) * 4 + $urandom_range(0, 3);
      else if (k == 8) addr = BASE + 4 * $urandom_range(8, 63) + $urandom_range(0, 3);
      else if (k == 9) addr = BASE - $urandom_range(1, 64);
      else addr = HIGH + $urandom_range(1, 64);
      wd  = $urandom;
      ben = 4'($urandom_range(0, 15));
      r   = 1'($urandom_range(0, 1));
      in_win   = (addr >= BASE) && (addr <= HIGH);
      idx      = (addr - BASE) / 4;
      exp_rd   = 32'h0;
      exp_strb = '0;
      if (in_win) begin
        if (r) exp_rd = model_read(idx);
        else model_write(idx, wd, ben, exp_strb);
      end
      for (int i = 0; i < NR; i++) exp_u[32*i +: 32] = m_reg[i];
      xfer(addr, r, ben, wd, acks, rd, strb, strb_late, u, idle_db);
      chk($sformatf("rnd%0d.ack", t), 128'(acks), in_win ? 128'd1 : 128'd0);
      chk($sformatf("rnd%0d.rd", t), 128'(rd), 128'(exp_rd));
      chk($sformatf("rnd%0d.strb", t), 128'(strb), 128'(exp_strb));
      chk($sformatf("rnd%0d.strb_late", t), 128'(strb_late), 0);
      chk($sformatf("rnd%0d.uout", t), u, exp_u);
      chk($sformatf("rnd%0d.idle_dbus", t), 128'(idle_db), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
